// File: rtl/lfsr_rng_pool_pkg.sv
// rtl/lfsr_rng_pool_pkg.sv - shared types, tap table and seed mix constant for the LFSR RNG pool
package veer_types;

    typedef enum logic {
        RNG_WARMUP = 1'b0,
        RNG_RUN    = 1'b1
    } rng_state_e;

    localparam logic [31:0] RNG_SEED_MIX = 32'h9E3779B9;

    // Tap n (1-based) maps to bit n-1 of the returned mask.
    function automatic logic [63:0] lfsr_taps(input int w);
        case (w)
            8:       return 64'h0000_0000_0000_00B8;
            16:      return 64'h0000_0000_0000_D008;
            32:      return 64'h0000_0000_8020_0003;
            64:      return 64'hD800_0000_0000_0000;
            default: return 64'h0;
        endcase
    endfunction

endpackage

// File: rtl/lfsr_rng_pool_arb.sv
// rtl/lfsr_rng_pool_arb.sv - round-robin arbiter with rotating priority pointer
module rng_rr_arb #(
    parameter int NCH = 2
) (
    input  logic           clk,
    input  logic           rst_l,
    input  logic           en,
    input  logic           clr,
    input  logic [NCH-1:0] req,
    output logic [NCH-1:0] gnt
);
    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [PW-1:0] ptr_q;
    logic          found;
    int            sel;
    int            idx;

    always_comb begin
        found = 1'b0;
        sel   = 0;
        idx   = 0;
        for (int i = 0; i < NCH; i++) begin
            idx = (int'(ptr_q) + i) % NCH;
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
        gnt = (en && found) ? (NCH'(1) << sel) : '0;
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            ptr_q <= '0;
        end else if (clr) begin
            ptr_q <= '0;
        end else if (en && found) begin
            ptr_q <= PW'((sel + 1) % NCH);
        end
    end

endmodule

// File: rtl/lfsr_rng_pool.sv
// rtl/lfsr_rng_pool.sv - shared XNOR-LFSR random word server for NCH round-robin requesters
module lfsr_rng_pool
    import veer_types::*;
#(
    parameter int LFSR_W     = 64,
    parameter int OUT_W      = 3,
    parameter int NCH        = 2,
    parameter int WARMUP_CYC = 8
) (
    input  logic                 clk,
    input  logic                 rst_l,
    input  logic [31:0]          seed_i,
    input  logic                 reseed_valid_i,
    input  logic [31:0]          reseed_seed_i,
    output logic                 reseed_ready_o,
    input  logic [NCH-1:0]       req_i,
    output logic [NCH-1:0]       gnt_o,
    output logic [NCH-1:0]       rnd_valid_o,
    output logic [NCH*OUT_W-1:0] rnd_o,
    output logic                 busy_o,
    output logic [31:0]          draw_cnt_o
);
    localparam logic [LFSR_W-1:0] TAPS      = LFSR_W'(lfsr_taps(LFSR_W));
    localparam logic [7:0]        WARM_INIT = 8'(WARMUP_CYC);
    localparam rng_state_e        START     = (WARMUP_CYC == 0) ? RNG_RUN : RNG_WARMUP;

    function automatic logic [LFSR_W-1:0] draw(input logic [LFSR_W-1:0] s);
        logic [LFSR_W-1:0] t;
        t = s;
        for (int i = 0; i < OUT_W; i++) begin
            t = {t[LFSR_W-2:0], ~^(t & TAPS)};
        end
        return t;
    endfunction

    // Narrow widths keep the raw seed; 64-bit fills the top half with a mixed copy.
    // The all-ones state is the XNOR lock-up point, so it is never loaded.
    function automatic logic [LFSR_W-1:0] expand(input logic [31:0] x);
        logic [LFSR_W-1:0] e;
        e = LFSR_W'({x ^ RNG_SEED_MIX, x});
        if (&e) begin
            e[0] = 1'b0;
        end
        return e;
    endfunction

    rng_state_e           state_q, state_d;
    logic [LFSR_W-1:0]    lfsr_q;
    logic [LFSR_W-1:0]    lfsr_nxt;
    logic [7:0]           warm_q;
    logic [31:0]          draw_cnt_q;
    logic [NCH*OUT_W-1:0] rnd_q;
    logic [NCH-1:0]       rnd_valid_q;
    logic [NCH-1:0]       gnt;
    logic                 run;
    logic                 reseed_go;

    assign run       = rst_l && (state_q == RNG_RUN);
    assign reseed_go = run && reseed_valid_i;
    assign lfsr_nxt  = draw(lfsr_q);

    rng_rr_arb #(.NCH(NCH)) u_arb (
        .clk   (clk),
        .rst_l (rst_l),
        .en    (run && !reseed_valid_i),
        .clr   (reseed_go),
        .req   (req_i),
        .gnt   (gnt)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            RNG_WARMUP: if (warm_q == 8'd1) state_d = RNG_RUN;
            RNG_RUN:    if (reseed_go) state_d = START;
            default:    state_d = START;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q <= START;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            lfsr_q      <= expand(seed_i);
            warm_q      <= WARM_INIT;
            draw_cnt_q  <= '0;
            rnd_q       <= '0;
            rnd_valid_q <= '0;
        end else begin
            rnd_valid_q <= gnt;
            if (state_q == RNG_WARMUP) begin
                lfsr_q <= lfsr_nxt;
                warm_q <= warm_q - 8'd1;
            end else if (reseed_go) begin
                lfsr_q     <= expand(reseed_seed_i);
                warm_q     <= WARM_INIT;
                draw_cnt_q <= '0;
            end else if (|gnt) begin
                lfsr_q     <= lfsr_nxt;
                draw_cnt_q <= draw_cnt_q + 32'd1;
                for (int k = 0; k < NCH; k++) begin
                    if (gnt[k]) rnd_q[k*OUT_W +: OUT_W] <= lfsr_nxt[OUT_W-1:0];
                end
            end
        end
    end

    assign gnt_o          = gnt;
    assign rnd_valid_o    = rnd_valid_q;
    assign rnd_o          = rnd_q;
    assign busy_o         = (state_q != RNG_RUN);
    assign reseed_ready_o = run;
    assign draw_cnt_o     = draw_cnt_q;

endmodule

// File: tb/tb_lfsr_rng_pool.sv
// tb/tb_lfsr_rng_pool.sv - scoreboard bench for two lfsr_rng_pool configurations
module tb_lfsr_rng_pool;

    logic clk;
    logic rst_l;
    logic [31:0] seed [2];
    logic [7:0]  req_v [2];
    logic        rs_v [2];
    logic [31:0] rs_seed [2];

    logic [2:0]  a_gnt, a_val, a_rnd;
    logic [1:0]  b_gnt, b_val;
    logic [5:0]  b_rnd;
    logic        a_busy, b_busy, a_rdy, b_rdy;
    logic [31:0] a_cnt, b_cnt;

    lfsr_rng_pool #(.LFSR_W(8), .OUT_W(1), .NCH(3), .WARMUP_CYC(0)) u_a (
        .clk(clk), .rst_l(rst_l), .seed_i(seed[0]),
        .reseed_valid_i(rs_v[0]), .reseed_seed_i(rs_seed[0]), .reseed_ready_o(a_rdy),
        .req_i(req_v[0][2:0]), .gnt_o(a_gnt), .rnd_valid_o(a_val), .rnd_o(a_rnd),
        .busy_o(a_busy), .draw_cnt_o(a_cnt)
    );

    lfsr_rng_pool #(.LFSR_W(64), .OUT_W(3), .NCH(2), .WARMUP_CYC(8)) u_b (
        .clk(clk), .rst_l(rst_l), .seed_i(seed[1]),
        .reseed_valid_i(rs_v[1]), .reseed_seed_i(rs_seed[1]), .reseed_ready_o(b_rdy),
        .req_i(req_v[1][1:0]), .gnt_o(b_gnt), .rnd_valid_o(b_val), .rnd_o(b_rnd),
        .busy_o(b_busy), .draw_cnt_o(b_cnt)
    );

    logic [63:0] o_gnt [2], o_val [2], o_rnd [2], o_cnt [2], o_busy [2], o_rdy [2];
    assign o_gnt[0]  = 64'(a_gnt);  assign o_gnt[1]  = 64'(b_gnt);
    assign o_val[0]  = 64'(a_val);  assign o_val[1]  = 64'(b_val);
    assign o_rnd[0]  = 64'(a_rnd);  assign o_rnd[1]  = 64'(b_rnd);
    assign o_cnt[0]  = 64'(a_cnt);  assign o_cnt[1]  = 64'(b_cnt);
    assign o_busy[0] = 64'(a_busy); assign o_busy[1] = 64'(b_busy);
    assign o_rdy[0]  = 64'(a_rdy);  assign o_rdy[1]  = 64'(b_rdy);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    function automatic int p_w(int i);  return (i == 0) ? 8 : 64; endfunction
    function automatic int p_ow(int i); return (i == 0) ? 1 : 3;  endfunction
    function automatic int p_nc(int i); return (i == 0) ? 3 : 2;  endfunction
    function automatic int p_wc(int i); return (i == 0) ? 0 : 8;  endfunction

    function automatic logic [63:0] wmask(int w);
        return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic [63:0] m_step(logic [63:0] s, int w);
        logic fb;
        if (w == 8) fb = ~(s[7] ^ s[5] ^ s[4] ^ s[3]);
        else        fb = ~(s[63] ^ s[62] ^ s[60] ^ s[59]);
        return ((s << 1) | 64'(fb)) & wmask(w);
    endfunction

    function automatic logic [63:0] m_draw(logic [63:0] s, int w, int ow);
        logic [63:0] t;
        t = s;
        for (int i = 0; i < ow; i++) t = m_step(t, w);
        return t;
    endfunction

    function automatic logic [63:0] m_expand(logic [31:0] x, int w);
        logic [63:0] e;
        e = (w == 64) ? {x ^ 32'h9E3779B9, x} : (64'(x) & wmask(w));
        if (e == wmask(w)) e[0] = 1'b0;
        return e;
    endfunction

    typedef struct {
        int          inst;
        int          ch;
        logic [63:0] word;
    } exp_t;
    exp_t sb_q [$];

    logic [63:0] m_lfsr [2];
    logic [63:0] m_rnd [2];
    logic [31:0] m_cnt [2];
    int          m_ptr [2];
    int          m_warm [2];
    logic        m_run [2];

    task automatic chk(input string tag, input int inst, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s[%0d] observed=%h expected=%h", tag, inst, obs, exp);
        end
    endtask

    task automatic model_init(input int i);
        m_lfsr[i] = m_expand(seed[i], p_w(i));
        m_rnd[i]  = '0;
        m_cnt[i]  = '0;
        m_ptr[i]  = 0;
        m_warm[i] = p_wc(i);
        m_run[i]  = (p_wc(i) == 0);
    endtask

    // Drops reset at the current time, checks the asynchronous clear, releases after an edge.
    task automatic do_reset(input logic [31:0] sa, input logic [31:0] sb);
        seed[0] = sa;
        seed[1] = sb;
        rst_l   = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_gnt", i, o_gnt[i], 64'd0);
            chk("rst_val", i, o_val[i], 64'd0);
            chk("rst_rnd", i, o_rnd[i], 64'd0);
            chk("rst_cnt", i, o_cnt[i], 64'd0);
            chk("rst_rdy", i, o_rdy[i], 64'd0);
            chk("rst_busy", i, o_busy[i], (p_wc(i) == 0) ? 64'd0 : 64'd1);
            model_init(i);
        end
        sb_q.delete();
        @(posedge clk);
        #1;
        rst_l = 1'b1;
    endtask

    task automatic cycle();
        logic [63:0] ev [2];
        logic [63:0] eg;
        exp_t        e;
        int          k;
        int          idx;
        int          nc;
        int          ow;
        #1;
        for (int i = 0; i < 2; i++) begin
            nc = p_nc(i);
            k  = -1;
            if (m_run[i] && !rs_v[i]) begin
                for (int j = 0; j < nc; j++) begin
                    idx = (m_ptr[i] + j) % nc;
                    if (k < 0 && req_v[i][idx]) k = idx;
                end
            end
            eg = (k >= 0) ? (64'd1 << k) : 64'd0;
            chk("gnt", i, o_gnt[i], eg);
            chk("ready", i, o_rdy[i], 64'(m_run[i]));
            chk("busy", i, o_busy[i], 64'(!m_run[i]));
            if (!m_run[i]) begin
                m_lfsr[i] = m_draw(m_lfsr[i], p_w(i), p_ow(i));
                if (m_warm[i] == 1) m_run[i] = 1'b1;
                m_warm[i]--;
            end else if (rs_v[i]) begin
                m_lfsr[i] = m_expand(rs_seed[i], p_w(i));
                m_cnt[i]  = '0;
                m_ptr[i]  = 0;
                m_warm[i] = p_wc(i);
                m_run[i]  = (p_wc(i) == 0);
            end else if (k >= 0) begin
                m_lfsr[i] = m_draw(m_lfsr[i], p_w(i), p_ow(i));
                sb_q.push_back('{inst: i, ch: k, word: m_lfsr[i] & wmask(p_ow(i))});
                m_ptr[i] = (k + 1) % nc;
                m_cnt[i]++;
            end
        end
        @(posedge clk);
        #1;
        ev[0] = '0;
        ev[1] = '0;
        while (sb_q.size() > 0) begin
            e  = sb_q.pop_front();
            ow = p_ow(e.inst);
            ev[e.inst] |= 64'd1 << e.ch;
            chk("word", e.inst, (o_rnd[e.inst] >> (e.ch * ow)) & wmask(ow), e.word);
            m_rnd[e.inst] = (m_rnd[e.inst] & ~(wmask(ow) << (e.ch * ow))) | (e.word << (e.ch * ow));
        end
        for (int i = 0; i < 2; i++) begin
            chk("valid", i, o_val[i], ev[i]);
            chk("rnd_hold", i, o_rnd[i], m_rnd[i]);
            chk("cnt", i, o_cnt[i], 64'(m_cnt[i]));
        end
    endtask

    initial begin
        rst_l      = 1'b1;
        req_v[0]   = 8'b000;
        req_v[1]   = 8'b11;
        rs_v[0]    = 1'b0;
        rs_v[1]    = 1'b0;
        rs_seed[0] = '0;
        rs_seed[1] = '0;
        seed[0]    = '0;
        seed[1]    = '0;
        #2;

        // Single draw from a zero seed; the wide instance warms up with requests pending.
        do_reset(32'h0, 32'h1234_5678);
        chk("t1_seed", 0, 64'(u_a.lfsr_q), 64'h00);
        req_v[0] = 8'b001;
        cycle();
        chk("t1_word", 0, o_rnd[0], 64'd1);
        chk("t1_cnt", 0, o_cnt[0], 64'd1);
        chk("t1_lfsr", 0, 64'(u_a.lfsr_q), 64'h01);
        req_v[0] = 8'b000;
        repeat (10) cycle();

        // All-ones seed is nudged off lock-up; a full period returns to the start.
        do_reset(32'h0000_00FF, 32'h0BAD_BEEF);
        chk("t2_seed", 0, 64'(u_a.lfsr_q), 64'hFE);
        req_v[0] = 8'b001;
        for (int n = 0; n < 255; n++) begin
            cycle();
            chk("t2_lfsr", 0, 64'(u_a.lfsr_q), m_lfsr[0]);
            chk("t2_lockup", 0, 64'(u_a.lfsr_q == 8'hFF), 64'd0);
        end
        chk("t2_period", 0, 64'(u_a.lfsr_q), 64'hFE);

        // Round-robin order with all requesters, then sparse patterns.
        do_reset(32'h0000_005A, 32'h0102_0304);
        req_v[0] = 8'b111;
        repeat (6) cycle();
        chk("t3_cnt", 0, o_cnt[0], 64'd6);
        req_v[0] = 8'b101; repeat (3) cycle();
        req_v[0] = 8'b010; repeat (2) cycle();
        req_v[0] = 8'b110; repeat (3) cycle();
        req_v[0] = 8'b000; repeat (2) cycle();

        // Reseed beats a pending request on both instances.
        req_v[0]   = 8'b111;
        req_v[1]   = 8'b10;
        rs_v[0]    = 1'b1;
        rs_seed[0] = 32'h0000_00FF;
        rs_v[1]    = 1'b1;
        rs_seed[1] = 32'hCAFE_F00D;
        cycle();
        chk("t5_gnt", 1, o_gnt[1], 64'd0);
        chk("t5_cnt", 1, o_cnt[1], 64'd0);
        chk("t5_fix", 0, 64'(u_a.lfsr_q), 64'hFE);
        rs_v[0]  = 1'b0;
        rs_v[1]  = 1'b0;
        req_v[1] = 8'b11;
        repeat (14) cycle();
        rs_v[1]    = 1'b1;
        rs_seed[1] = 32'h7777_0001;
        cycle();
        rs_v[1] = 1'b0;
        repeat (3) cycle();

        // Asynchronous reset mid-draw and mid-warm-up, then the first stream again.
        req_v[0] = 8'b001;
        #1;
        do_reset(32'h0, 32'h1234_5678);
        req_v[0] = 8'b001;
        cycle();
        chk("t6_word", 0, o_rnd[0], 64'd1);
        chk("t6_cnt", 0, o_cnt[0], 64'd1);
        chk("t6_lfsr", 0, 64'(u_a.lfsr_q), 64'h01);
        req_v[0] = 8'b111;
        repeat (12) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
